seq_mult_acc_ctrl: RTL and testbench

Control FSM plus shift-add accumulator for the 16x9 sequential multiplier, directly downstream of the 9-bit multiplier shift register (ShiftMy).
- Drives that shifter's LD_MY/SFT_MY strobes and consumes its serial MY_BIT, one bit per cycle, LSB first.
- Produces the 25-bit product after 9 add/shift steps, with a BUSY/DONE handshake to the top level.

---
 rtl/seq_mult_pkg.sv | 14 +
 rtl/seq_mult_acc_ctrl_if.sv | 21 ++
 rtl/shift_add_acc.sv | 50 +++++
 rtl/seq_mult_acc_ctrl.sv | 63 ++++++
 tb/tb_seq_mult_acc_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/seq_mult_pkg.sv
// Shared widths and FSM state type for the 16x9 sequential shift-add multiplier.
package seq_mult_pkg;
  localparam int MX_W  = 16;
  localparam int MY_W  = 9;
  localparam int P_W   = MX_W + MY_W;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/seq_mult_acc_ctrl_if.sv
// Handshake and shifter-strobe bundle between the multiplier controller and its surroundings.
interface seq_mult_acc_ctrl_if;
  logic                       START;
  logic [seq_mult_pkg::MX_W-1:0] IN_MX;
  logic                       MY_BIT;
  logic                       LD_MY;
  logic                       SFT_MY;
  logic                       BUSY;
  logic                       DONE;
  logic [seq_mult_pkg::P_W-1:0]  PRODUCT;

  modport master (
    output START, IN_MX, MY_BIT,
    input  LD_MY, SFT_MY, BUSY, DONE, PRODUCT
  );

  modport slave (
    input  START, IN_MX, MY_BIT,
    output LD_MY, SFT_MY, BUSY, DONE, PRODUCT
  );
endinterface

// File: rtl/shift_add_acc.sv
// Product high/low registers, multiplicand latch and one unsigned add-shift step per cycle.
module shift_add_acc
  import seq_mult_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_cap,
  input  logic            i_step,
  input  logic            i_my_bit,
  input  logic [MX_W-1:0] i_mx,
  output logic [MX_W-1:0] o_ph,
  output logic [MY_W-1:0] o_pl
);

  logic [MX_W-1:0] r_ph;
  logic [MY_W-1:0] r_pl;
  logic [MX_W-1:0] r_mxr;
  logic [MX_W:0]   w_sum;

  // The extra MSB holds the carry so the high half never loses a bit.
  function automatic logic [MX_W:0] add_step(input logic [MX_W-1:0] ph,
                                             input logic [MX_W-1:0] mxr,
                                             input logic            bit_i);
    return {1'b0, ph} + (bit_i ? {1'b0, mxr} : {(MX_W+1){1'b0}});
  endfunction

  assign w_sum = add_step(r_ph, r_mxr, i_my_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph  <= '0;
      r_pl  <= '0;
      r_mxr <= '0;
    end else begin
      if (i_cap) r_mxr <= i_mx;
      if (i_clr) begin
        r_ph <= '0;
        r_pl <= '0;
      end else if (i_step) begin
        r_ph <= w_sum[MX_W:1];
        r_pl <= {w_sum[0], r_pl[MY_W-1:1]};
      end
    end
  end

  assign o_ph = r_ph;
  assign o_pl = r_pl;

endmodule

// File: rtl/seq_mult_acc_ctrl.sv
// Control FSM for the 16x9 shift-add multiplier: drives the multiplier shifter and sequences MY_W steps.
module seq_mult_acc_ctrl
  import seq_mult_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  seq_mult_acc_ctrl_if.slave bus
);

  state_e           r_state;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;
  logic             w_step;
  logic [MX_W-1:0]  w_ph;
  logic [MY_W-1:0]  w_pl;

  assign w_accept = (r_state == IDLE) && bus.START;
  assign w_step   = (r_state == RUN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.START) begin
          r_state <= LOAD;
          r_count <= '0;
        end
        LOAD: r_state <= RUN;
        RUN: begin
          r_count <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(MY_W - 1)) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  shift_add_acc u_acc (
    .clk      (CLK),
    .rst      (RST),
    .i_clr    (w_accept),
    .i_cap    (w_accept),
    .i_step   (w_step),
    .i_my_bit (bus.MY_BIT),
    .i_mx     (bus.IN_MX),
    .o_ph     (w_ph),
    .o_pl     (w_pl)
  );

  // Pure state decodes: no input reaches these outputs combinationally.
  assign bus.LD_MY   = (r_state == LOAD);
  assign bus.SFT_MY  = (r_state == RUN);
  assign bus.DONE    = (r_state == DONE);
  assign bus.BUSY    = (r_state != IDLE);
  assign bus.PRODUCT = {w_ph, w_pl};

  a_done_to_idle: assert property (@(posedge CLK) disable iff (RST)
    (r_state == DONE) |=> (r_state == IDLE));

endmodule

// File: tb/tb_seq_mult_acc_ctrl.sv
// Bench for seq_mult_acc_ctrl with a behavioural multiplier shifter and an arithmetic product model.
module tb_seq_mult_acc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  in_my = '0;
  logic [8:0]  r_sh = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  seq_mult_acc_ctrl_if bus ();

  seq_mult_acc_ctrl dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.LD_MY)       r_sh <= in_my;
    else if (bus.SFT_MY) r_sh <= r_sh >> 1;
  end
  assign bus.MY_BIT = r_sh[0];

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One multiply from an IDLE cycle n; optional second START pulse during cycle n+inject_at.
  task automatic run_op(input logic [15:0] mx, input logic [8:0] my, input int inject_at,
                        input string tag);
    logic [24:0] exp_p;
    int nsft;
    int ndone;
    exp_p = 25'(mx) * 25'(my);
    nsft = 0;
    ndone = 0;
    bus.START = 1'b1;
    bus.IN_MX = mx;
    in_my     = my;
    for (int j = 1; j <= 11; j++) begin
      tick();
      if (j == 1) bus.START = 1'b0;
      if (inject_at > 0 && j == inject_at) begin
        bus.START = 1'b1;
        bus.IN_MX = 16'h0001;
      end
      if (inject_at > 0 && j == inject_at + 1) bus.START = 1'b0;
      if (bus.SFT_MY === 1'b1) nsft++;
      if (bus.DONE === 1'b1) ndone++;
      chk({tag, "_ld"},   32'(bus.LD_MY),  32'(j == 1));
      chk({tag, "_sft"},  32'(bus.SFT_MY), 32'(j >= 2 && j <= 10));
      chk({tag, "_done"}, 32'(bus.DONE),   32'(j == 11));
      chk({tag, "_busy"}, 32'(bus.BUSY),   32'd1);
    end
    chk({tag, "_product"}, 32'(bus.PRODUCT), 32'(exp_p));
    chk({tag, "_nsft"},    32'(nsft),        32'd9);
    tick();
    chk({tag, "_idle_busy"}, 32'(bus.BUSY),    32'd0);
    chk({tag, "_hold"},      32'(bus.PRODUCT), 32'(exp_p));
    if (inject_at > 0) begin
      for (int j = 0; j < 14; j++) begin
        tick();
        if (bus.DONE === 1'b1) ndone++;
      end
      chk({tag, "_ndone"},    32'(ndone),       32'd1);
      chk({tag, "_unchanged"}, 32'(bus.PRODUCT), 32'(exp_p));
    end
  endtask

  initial begin
    logic [15:0] mx_v;
    logic [8:0]  my_v;
    logic [24:0] exp_p;
    int          last_done;
    bus.START = 1'b0;
    bus.IN_MX = '0;

    tick();
    tick();
    chk("rst_busy",    32'(bus.BUSY),    32'd0);
    chk("rst_done",    32'(bus.DONE),    32'd0);
    chk("rst_ld",      32'(bus.LD_MY),   32'd0);
    chk("rst_sft",     32'(bus.SFT_MY),  32'd0);
    chk("rst_product", 32'(bus.PRODUCT), 32'd0);
    rst = 1'b0;
    tick();

    run_op(16'h1234, 9'h005, 0, "basic");
    run_op(16'hFFFF, 9'h1FF, 0, "max");
    run_op(16'h8000, 9'h100, 0, "single");
    run_op(16'hABCD, 9'h000, 0, "zero_my");
    run_op(16'h0000, 9'h1FF, 0, "zero_mx");
    run_op(16'h4321, 9'h0A5, 5, "busy_start");

    for (int i = 0; i < 8; i++) begin
      mx_v = 16'($urandom);
      my_v = 9'($urandom);
      run_op(mx_v, my_v, 0, "rand");
    end

    // Abort in the middle of RUN, then restart from scratch.
    bus.START = 1'b1;
    bus.IN_MX = 16'hBEEF;
    in_my     = 9'h1AB;
    tick();
    bus.START = 1'b0;
    for (int j = 2; j <= 6; j++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy",    32'(bus.BUSY),    32'd0);
    chk("midrst_done",    32'(bus.DONE),    32'd0);
    chk("midrst_sft",     32'(bus.SFT_MY),  32'd0);
    chk("midrst_product", 32'(bus.PRODUCT), 32'd0);
    run_op(16'd3, 9'd7, 0, "after_rst");
    chk("after_rst_val", 32'(bus.PRODUCT), 32'd21);

    // START held high: new operands are presented while DONE is showing.
    last_done = 0;
    mx_v = 16'($urandom);
    my_v = 9'($urandom);
    bus.IN_MX = mx_v;
    in_my     = my_v;
    bus.START = 1'b1;
    for (int op = 0; op < 3; op++) begin
      exp_p = 25'(mx_v) * 25'(my_v);
      for (int c = 0; c < 30; c++) begin
        tick();
        if (bus.DONE === 1'b1) break;
      end
      chk("b2b_done_seen", 32'(bus.DONE),    32'd1);
      chk("b2b_product",   32'(bus.PRODUCT), 32'(exp_p));
      if (op > 0) chk("b2b_gap", 32'(cyc - last_done), 32'd12);
      last_done = cyc;
      mx_v = 16'($urandom);
      my_v = 9'($urandom);
      bus.IN_MX = mx_v;
      in_my     = my_v;
    end
    bus.START = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
